// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enable/flush, PC enable, fetch gating, sticky halt
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             halt_EX_MEM,
    input  logic             branch_taken_EX_MEM,
    input  logic             jump_ID,
    input  logic             dREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    output logic             pc_en,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             imem_gate,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic mem_op;
    logic load_use;
    logic advance;
    logic stall_ev;
    logic flush_ev;

    assign mem_op   = dREN_EX_MEM | dWEN_EX_MEM;
    assign load_use = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                      ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

    always_comb begin
        state_d       = state_q;
        advance       = 1'b0;
        stall_ev      = 1'b0;
        imem_gate     = 1'b0;
        pc_en         = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_EX_MEM  = 1'b0;

        case (state_q)
            RUN: begin
                imem_gate = 1'b1;
                advance   = mem_op ? dhit : ihit;
                if (mem_op && !dhit) state_d = DWAIT;
            end
            DWAIT: begin
                // Fetch is held off the cache arbiter while the data side owns it.
                advance = dhit;
                if (dhit) state_d = RUN;
            end
            default: ;
        endcase

        if (state_q != HALTED) begin
            if (advance) begin
                if (branch_taken_EX_MEM) begin
                    pc_en         = 1'b1;
                    enable_IF_ID  = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                    flush_IF_ID   = 1'b1;
                    flush_ID_EX   = 1'b1;
                    flush_EX_MEM  = 1'b1;
                end else if (load_use) begin
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                    flush_ID_EX   = 1'b1;
                end else begin
                    pc_en         = 1'b1;
                    enable_IF_ID  = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                    flush_IF_ID   = jump_ID;
                end
                // The halting instruction still advances so it retires through MEM/WB.
                if (halt_EX_MEM) state_d = HALTED;
            end
            stall_ev = !advance || (load_use && !branch_taken_EX_MEM);
        end
    end

    assign flush_ev = flush_IF_ID | flush_ID_EX | flush_EX_MEM;
    assign stall_d  = (stall_ev && stall_q != CNT_MAX) ? stall_q + CNT_ONE : stall_q;
    assign flush_d  = (flush_ev && flush_q != CNT_MAX) ? flush_q + CNT_ONE : flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halt        = (state_q == HALTED);
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver queues a hand-computed expected
// output packet per cycle, the monitor pops and compares it on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 3;
    localparam int PW    = 10 + 2 + CNT_W + CNT_W;

    // Control packet: {pc_en, en IF/ID ID/EX EX/MEM MEM/WB, fl IF/ID ID/EX EX/MEM, imem_gate, halt}
    localparam logic [9:0] C_RUN_ADV   = 10'b1_1111_000_1_0;
    localparam logic [9:0] C_RUN_STALL = 10'b0_0000_000_1_0;
    localparam logic [9:0] C_DW_STALL  = 10'b0_0000_000_0_0;
    localparam logic [9:0] C_DW_ADV    = 10'b1_1111_000_0_0;
    localparam logic [9:0] C_LU        = 10'b0_0111_010_1_0;
    localparam logic [9:0] C_BR        = 10'b1_1111_111_1_0;
    localparam logic [9:0] C_JMP       = 10'b1_1111_100_1_0;
    localparam logic [9:0] C_HALTED    = 10'b0_0000_000_0_1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DWAIT = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Stimulus flags: {ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt, branch, jump, dREN_ID_EX}
    localparam logic [7:0] I_IHIT = 8'b1000_0000;
    localparam logic [7:0] I_DHIT = 8'b0100_0000;
    localparam logic [7:0] I_DREN = 8'b0010_0000;
    localparam logic [7:0] I_DWEN = 8'b0001_0000;
    localparam logic [7:0] I_HALT = 8'b0000_1000;
    localparam logic [7:0] I_BR   = 8'b0000_0100;
    localparam logic [7:0] I_JMP  = 8'b0000_0010;
    localparam logic [7:0] I_LU   = 8'b0000_0001;

    logic CLK, nRST;
    logic ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, branch_taken_EX_MEM, jump_ID, dREN_ID_EX;
    logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
    logic pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
    logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, imem_gate, halt;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [1:0] state_dbg;

    logic [PW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
        .branch_taken_EX_MEM(branch_taken_EX_MEM), .jump_ID(jump_ID), .dREN_ID_EX(dREN_ID_EX),
        .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
        .pc_en(pc_en), .enable_IF_ID(enable_IF_ID), .enable_ID_EX(enable_ID_EX),
        .enable_EX_MEM(enable_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .imem_gate(imem_gate), .halt(halt), .stall_count(stall_count),
        .flush_count(flush_count), .state_dbg(state_dbg)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Driver: inputs change 1 time unit after the rising edge
    task automatic step(input logic nrst, input logic [7:0] f,
                        input logic [4:0] rt_ie, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [9:0] ectl, input logic [1:0] est,
                        input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef,
                        input string nm);
        @(posedge CLK);
        #1;
        nRST = nrst;
        {ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, branch_taken_EX_MEM, jump_ID, dREN_ID_EX} = f;
        Rt_ID_EX = rt_ie;
        Rs_IF_ID = rs;
        Rt_IF_ID = rt;
        exp_q.push_back({ectl, est, es, ef});
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [PW-1:0] exp_v, got_v;
        string nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                got_v = {pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
                         flush_IF_ID, flush_ID_EX, flush_EX_MEM, imem_gate, halt,
                         state_dbg, stall_count, flush_count};
                n_checks++;
                if (got_v === exp_v) n_pass++;
                else $display("FAIL %s: got %b expected %b (ctl|state|stall|flush)", nm, got_v, exp_v);
            end
        end
    end

    initial begin
        nRST = 1'b0;
        {ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, branch_taken_EX_MEM, jump_ID, dREN_ID_EX} = '0;
        Rt_ID_EX = '0; Rs_IF_ID = '0; Rt_IF_ID = '0;

        step(1'b0, I_IHIT, 0, 0, 0, C_RUN_ADV, S_RUN, 0, 0, "reset_run");
        for (int i = 0; i < 10; i++)
            step(1'b1, I_IHIT, 0, 0, 0, C_RUN_ADV, S_RUN, 0, 0, "run_clean");
        step(1'b1, 8'h00,                 0, 0, 0, C_RUN_STALL, S_RUN,   0, 0, "no_ihit");
        step(1'b1, I_IHIT | I_DREN,       0, 0, 0, C_RUN_STALL, S_RUN,   1, 0, "load_miss");
        step(1'b1, I_IHIT | I_DREN,       0, 0, 0, C_DW_STALL,  S_DWAIT, 2, 0, "dwait_1");
        step(1'b1, I_IHIT | I_DREN,       0, 0, 0, C_DW_STALL,  S_DWAIT, 3, 0, "dwait_2");
        step(1'b1, I_IHIT | I_DREN | I_DHIT, 0, 0, 0, C_DW_ADV, S_DWAIT, 4, 0, "dwait_hit");
        step(1'b1, I_DREN | I_DHIT,       0, 0, 0, C_RUN_ADV,   S_RUN,   4, 0, "load_hit_no_ihit");
        step(1'b1, I_IHIT | I_DWEN,       0, 0, 0, C_RUN_STALL, S_RUN,   4, 0, "store_miss");
        step(1'b1, I_DWEN | I_DHIT,       0, 0, 0, C_DW_ADV,    S_DWAIT, 5, 0, "store_hit");
        step(1'b1, I_IHIT | I_LU,         5, 5, 0, C_LU,        S_RUN,   5, 0, "lu_rs");
        step(1'b1, I_IHIT | I_LU,         7, 3, 7, C_LU,        S_RUN,   6, 1, "lu_rt");
        step(1'b1, I_IHIT | I_LU,         0, 0, 0, C_RUN_ADV,   S_RUN,   7, 2, "lu_r0");
        step(1'b1, I_IHIT,                5, 5, 0, C_RUN_ADV,   S_RUN,   7, 2, "no_load");
        step(1'b1, I_IHIT | I_JMP,        0, 0, 0, C_JMP,       S_RUN,   7, 2, "jump");
        step(1'b1, I_IHIT | I_BR | I_JMP | I_LU, 5, 5, 0, C_BR, S_RUN,   7, 3, "branch_over");
        step(1'b1, I_LU,                  5, 5, 0, C_RUN_STALL, S_RUN,   7, 4, "lu_no_ihit");
        step(1'b1, I_IHIT | I_HALT,       0, 0, 0, C_RUN_ADV,   S_RUN,   7, 4, "halt_sat");
        for (int i = 0; i < 20; i++)
            step(1'b1, I_IHIT | I_BR | I_JMP | I_DREN, 0, 0, 0, C_HALTED, S_HALT, 7, 4, "halted_hold");
        step(1'b0, I_IHIT,                0, 0, 0, C_RUN_ADV,   S_RUN,   0, 0, "reset_from_halt");
        step(1'b1, I_IHIT | I_HALT | I_BR, 0, 0, 0, C_BR,       S_RUN,   0, 0, "halt_branch");
        step(1'b1, I_IHIT,                0, 0, 0, C_HALTED,    S_HALT,  0, 1, "halted_after_br");
        step(1'b0, 8'h00,                 0, 0, 0, C_RUN_STALL, S_RUN,   0, 0, "reset_2");
        step(1'b1, 8'h00,                 0, 0, 0, C_RUN_STALL, S_RUN,   0, 0, "idle");
        step(1'b1, I_DREN,                0, 0, 0, C_RUN_STALL, S_RUN,   1, 0, "miss_again");
        step(1'b1, I_DREN,                0, 0, 0, C_DW_STALL,  S_DWAIT, 2, 0, "dwait_again");
        step(1'b0, I_DREN,                0, 0, 0, C_RUN_STALL, S_RUN,   0, 0, "reset_in_dwait");
        step(1'b1, I_IHIT,                0, 0, 0, C_RUN_ADV,   S_RUN,   0, 0, "after_reset");

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives every register's enable and flush, plus the PC enable.
- Freezes the pipeline on instruction/data cache misses, inserts load-use bubbles, squashes wrong-path instructions on taken branches and jumps, and latches a sticky halt.
- Keeps stall and flush performance counters for the cpu tracker.

Parameters:
CNT_W, 32, width of the stall_count and flush_count performance counters (saturating).

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
dREN_EX_MEM  in  1  load in MEM stage
dWEN_EX_MEM  in  1  store in MEM stage
halt_EX_MEM  in  1  halt instruction in MEM stage
branch_taken_EX_MEM  in  1  branch/JR resolved taken in MEM stage
jump_ID  in  1  J/JAL decoded in ID stage
dREN_ID_EX  in  1  load in EX stage
Rt_ID_EX  in  5  load destination register in EX stage
Rs_IF_ID  in  5  rs field of the ID instruction
Rt_IF_ID  in  5  rt field of the ID instruction
pc_en  out  1  PC update enable
enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  pipeline register enables
flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  insert bubble into the register
imem_gate  out  1  1 = instruction fetch permitted to the cache arbiter
halt  out  1  sticky CPU halt
stall_count  out  CNT_W  cycles with no advance while in RUN/DWAIT
flush_count  out  CNT_W  number of flush events

Behaviour:
- State machine, 3 states: RUN, DWAIT, HALTED.
- Reset (async, nRST=0):
  - state=RUN; halt=0; both counters=0.
  - Combinational outputs then follow the RUN equations.
- Derived signals:
  - mem_op = dREN_EX_MEM | dWEN_EX_MEM.
  - advance = mem_op ? dhit : ihit. In RUN with a mem_op, advance also requires dhit.
  - load_use = dREN_ID_EX & (Rt_ID_EX != 0) & (Rt_ID_EX == Rs_IF_ID | Rt_ID_EX == Rt_IF_ID).
- RUN:
  - imem_gate=1.
  - If mem_op & ~dhit: next state DWAIT; all enables 0.
- DWAIT:
  - imem_gate=0; all enables and flushes 0 until dhit.
  - On dhit: advance that cycle, apply normal rules, next state RUN.
- When advance=1, apply the first matching rule:
  1. branch_taken_EX_MEM: all enables 1, pc_en=1, flush_IF_ID=flush_ID_EX=flush_EX_MEM=1. This overrides load_use and jump_ID.
  2. load_use: pc_en=0, enable_IF_ID=0, enable_ID_EX=1 with flush_ID_EX=1, enable_EX_MEM=enable_MEM_WB=1.
  3. jump_ID: all enables 1, pc_en=1, flush_IF_ID=1.
  4. Otherwise: all enables 1, pc_en=1, no flushes.
- When advance=0: all enables and flushes 0.
- Flushes are only ever asserted together with the matching enable.
- Halt:
  - halt_EX_MEM & advance → next state HALTED.
  - That transition still advances, so the halt instruction reaches MEM/WB.
  - In HALTED: halt=1 (registered, first cycle after the transition), imem_gate=0, all enables and flushes 0.
  - HALTED is left only by reset.
  - If halt_EX_MEM and branch_taken_EX_MEM are both set, the halt wins: HALTED is entered and flushes are still applied that cycle.
- Counters:
  - stall_count increments by 1 on every RUN/DWAIT cycle where advance=0, or advance=1 with load_use and no branch.
  - flush_count increments by 1 per cycle in which any flush output is 1.
  - Both saturate at 2^CNT_W-1 and freeze in HALTED.
- Reset asserted mid-DWAIT or in HALTED returns asynchronously to RUN with counters cleared.
- All outputs other than halt, the counters and the state are combinational from state and inputs. Latency 0.

Test Plan:
- Reset then ihit=1, no hazards → all enables=1, pc_en=1, flushes=0, stall_count=0 after 10 cycles.
- dREN_EX_MEM=1, dhit=0 for 3 cycles then 1 → state DWAIT, enables=0 and imem_gate=0 for 3 cycles; advance on the dhit cycle; stall_count=3.
- dREN_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 → pc_en=0, enable_IF_ID=0, flush_ID_EX=1; stall_count +1. Repeat with Rt_ID_EX=0 → no bubble.
- branch_taken_EX_MEM=1 together with load_use and jump_ID, ihit=1 → three flushes=1, pc_en=1; flush_count +1.
- halt_EX_MEM=1, ihit=1 → next cycle halt=1, all enables=0. ihit held 1 for 20 cycles → still halted, counters unchanged. nRST pulse → halt=0, RUN.
- nRST asserted in DWAIT → immediate RUN, counters=0, imem_gate=1.
